// File: rtl/cam_pkg.sv
// Shared constants and state encoding for the OV7670 frame-buffer writer.
package cam_pkg;

    localparam int H_PIX_QQVGA   = 160;
    localparam int V_LINES_QQVGA = 120;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        ACTIVE = 2'd2,
        DONE   = 2'd3
    } cam_state_t;

endpackage

// File: rtl/cam_frame_writer_if.sv
// Pixel stream in from the RGB332 converter and write port out to the frame buffer.
interface cam_frame_writer_if #(
    parameter int AW = 15
);
    logic          px_valid;
    logic [7:0]    px_data;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_data;

    // Environment side: produces pixels, observes buffer writes.
    modport master (
        output px_valid,
        output px_data,
        input  mem_we,
        input  mem_addr,
        input  mem_data
    );

    // Writer side: consumes pixels, drives the buffer write port.
    modport slave (
        input  px_valid,
        input  px_data,
        output mem_we,
        output mem_addr,
        output mem_data
    );
endinterface

// File: rtl/sync_edge.sv
// One-cycle delay of a camera framing signal with rise/fall detection.
// RESET_VAL chooses what the "previous" value looks like right after reset.
module sync_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic pclk,
    input  logic rst,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic q;

    // Remember last cycle's level of the input.
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) q <= RESET_VAL;
        else      q <= d;
    end

    assign rise = ~q & d;
    assign fall = q & ~d;

endmodule

// File: rtl/cam_frame_writer.sv
// Frames the converted pixel stream with VSYNC/HREF and writes it linearly
// into the frame buffer, with frame-done pulse and sticky framing errors.
module cam_frame_writer
    import cam_pkg::*;
#(
    parameter int H_PIX   = H_PIX_QQVGA,
    parameter int V_LINES = V_LINES_QQVGA,
    parameter int AW      = 15
) (
    input  logic                pclk,
    input  logic                rst,
    input  logic                cap_en,
    input  logic                vsync,
    input  logic                href,
    input  logic                err_clr,
    cam_frame_writer_if.slave   bus,
    output logic                busy,
    output logic                frame_done,
    output logic                err_long,
    output logic                err_short,
    output logic                err_frame
);

    localparam int XW = $clog2(H_PIX + 1);
    localparam int YW = $clog2(V_LINES + 1);
    localparam logic [XW-1:0] X_MAX     = XW'(H_PIX);
    localparam logic [YW-1:0] Y_MAX     = YW'(V_LINES);
    localparam logic [AW-1:0] LINE_STEP = AW'(H_PIX);

    cam_state_t    state, state_nxt;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [YW-1:0] y_inc;
    logic [AW-1:0] addr;
    logic [AW-1:0] line_base;

    logic vs_rise, vs_fall, hr_fall, unused_hr_rise;
    logic start_frame, wr_ok, px_drop, line_end, set_short, set_frame;

    // VSYNC idles high so a capture never starts from a reset-time level.
    sync_edge #(.RESET_VAL(1'b1)) u_vs_edge (
        .pclk (pclk),
        .rst  (rst),
        .d    (vsync),
        .rise (vs_rise),
        .fall (vs_fall)
    );

    sync_edge #(.RESET_VAL(1'b0)) u_hr_edge (
        .pclk (pclk),
        .rst  (rst),
        .d    (href),
        .rise (unused_hr_rise),
        .fall (hr_fall)
    );

    assign y_inc = y + YW'(1);

    // State register.
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next state plus per-cycle datapath strobes.
    always_comb begin
        state_nxt   = state;
        start_frame = 1'b0;
        wr_ok       = 1'b0;
        px_drop     = 1'b0;
        line_end    = 1'b0;
        set_short   = 1'b0;
        set_frame   = 1'b0;
        case (state)
            IDLE: begin
                if (cap_en) state_nxt = ARMED;
            end
            ARMED: begin
                if (vs_fall) begin
                    state_nxt   = ACTIVE;
                    start_frame = 1'b1;
                end else if (!cap_en) begin
                    state_nxt = IDLE;
                end
            end
            ACTIVE: begin
                if (bus.px_valid && href) begin
                    if (x < X_MAX && y < Y_MAX) wr_ok   = 1'b1;
                    else                        px_drop = 1'b1;
                end
                if (hr_fall && x != '0) begin
                    line_end  = 1'b1;
                    set_short = (x < X_MAX);
                end
                // A line end on the last line wins over a coincident VSYNC rise.
                if (line_end && y_inc == Y_MAX) begin
                    state_nxt = DONE;
                end else if (vs_rise) begin
                    set_frame = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = cap_en ? ARMED : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Position counters; addresses advance by adding a line stride, no multiply.
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            x         <= '0;
            y         <= '0;
            addr      <= '0;
            line_base <= '0;
        end else if (start_frame) begin
            x         <= '0;
            y         <= '0;
            addr      <= '0;
            line_base <= '0;
        end else begin
            if (wr_ok) begin
                x    <= x + XW'(1);
                addr <= addr + AW'(1);
            end
            if (line_end) begin
                x         <= '0;
                y         <= y_inc;
                line_base <= line_base + LINE_STEP;
                addr      <= line_base + LINE_STEP;
            end
        end
    end

    // Registered write port: one write cycle per accepted pixel.
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            bus.mem_we   <= 1'b0;
            bus.mem_addr <= '0;
            bus.mem_data <= '0;
        end else begin
            bus.mem_we <= wr_ok;
            if (wr_ok) begin
                bus.mem_addr <= addr;
                bus.mem_data <= bus.px_data;
            end
        end
    end

    // Sticky error flags; a new error in the clear cycle stays set.
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            err_long  <= 1'b0;
            err_short <= 1'b0;
            err_frame <= 1'b0;
        end else begin
            err_long  <= px_drop   | (err_long  & ~err_clr);
            err_short <= set_short | (err_short & ~err_clr);
            err_frame <= set_frame | (err_frame & ~err_clr);
        end
    end

    assign busy       = (state == ARMED) || (state == ACTIVE);
    assign frame_done = (state == DONE);

endmodule
